math_computer_driver: RTL
=========================

MATH_COMPUTER_DRIVER -- requirements
Module: math_computer_driver

Interface
REQ-001 Parameter NB_TRANS_W, default 8, width of transaction count and index.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for a result (package constant MC_TIMEOUT).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse, launches a sequence when idle.
REQ-006 nb_trans  input  NB_TRANS_W  number of transactions, sampled on accepted start.
REQ-007 a_init  input  DATASIZE  first a operand, sampled on accepted start.
REQ-008 b_init  input  DATASIZE  first b operand, sampled on accepted start.
REQ-009 input_port  math_computer_input_itf.master  -  drives valid, a, b, c (DATASIZE each); receives ready.
REQ-010 output_port  math_computer_output_itf.slave  -  drives ready; receives valid, result (DATASIZE+1).
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse at sequence end.
REQ-013 err_count  output  8  mismatched results, saturating at 255.
REQ-014 timeout_flag  output  1  sticky until next accepted start; set on result timeout.

Function
REQ-015 FSM states: IDLE, SEND, WAIT_RES, FINISH.
REQ-016 IDLE: start=1 -> latch inputs, clear index, err_count, timeout_flag; go SEND, or FINISH if nb_trans=0.
REQ-017 start in any state other than IDLE is ignored.
REQ-018 Transaction i operands: a = a_init + i, b = b_init - i, both modulo 2^DATASIZE; c = a XOR b.
REQ-019 SEND: input_port.valid=1 with a, b, c stable until the cycle valid && ready; then valid=0 next cycle, go WAIT_RES.
REQ-020 At most one transaction is outstanding; valid never asserts in WAIT_RES.
REQ-021 WAIT_RES: output_port.ready=1; ready=0 in all other states.
REQ-022 On output_port.valid && ready: compare result with expected = zero-extended a + b on DATASIZE+1 bits (carry kept); mismatch -> err_count+1, saturating.
REQ-023 After a result: index+1; index = nb_trans -> FINISH, else SEND, with no idle cycle.
REQ-024 WAIT_RES timeout counter reloads on SEND->WAIT_RES; after TIMEOUT cycles without result -> timeout_flag=1, go FINISH, remaining transactions dropped.
REQ-025 FINISH: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE only.
REQ-026 err_count and timeout_flag hold their values in IDLE until the next accepted start.
REQ-027 output_port.valid while not in WAIT_RES is not acknowledged and not counted.

Reset
REQ-028 rst=1 -> IDLE; input_port.valid, a, b, c, output_port.ready, busy, done, err_count, timeout_flag, index, timeout counter all 0.
REQ-029 rst mid-sequence aborts immediately; no done pulse is generated for the aborted sequence.

Structure
REQ-030 Package math_computer_pkg holds the state enum typedef, MC_TIMEOUT, and the 8-bit error counter width.
REQ-031 DATASIZE comes from the existing math_computer macros file.
REQ-032 No sub-module; the single process FSM plus combinational expected-value compare stays in one module.

Verification
REQ-033 DATASIZE=8, start, nb_trans=3, a_init=10, b_init=5, DUT math_computer -> results 15, 15, 15; err_count=0; done pulse once; busy 0 after.
REQ-034 a_init=255, b_init=1, nb_trans=2 -> first expected 256 (carry), second a=0 (wrap), b=0, expected 0; err_count=0.
REQ-035 Responder stub returning result+1 for every transaction, nb_trans=4 -> err_count=4, done asserted.
REQ-036 Responder never asserts output valid, TIMEOUT=16 -> timeout_flag=1 and done 16 cycles after the input handshake; err_count=0.
REQ-037 start with nb_trans=0 -> no input valid, done one cycle after IDLE exit; start pulses during busy -> no effect on count.
REQ-038 rst asserted while in WAIT_RES at transaction 2 of 5 -> all outputs 0 next edge; new start then runs a full 5-transaction sequence.

Source files
------------

// File: rtl/math_computer_pkg.sv
// math_computer_pkg: shared state type, data width and limits for the math computer driver
// DATASIZE is taken from the math_computer macro when a macros file defines it first.
`ifndef MATH_COMPUTER_DATASIZE
`define MATH_COMPUTER_DATASIZE 8
`endif
package math_computer_pkg;
  localparam int DATASIZE   = `MATH_COMPUTER_DATASIZE;
  localparam int MC_TIMEOUT = 255;
  localparam int MC_ERR_W   = 8;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, FINISH} mc_state_e;
endpackage

// File: rtl/math_computer_itf.sv
// math_computer_itf: operand and result handshake interfaces of the math computer
// input:  valid/a/b/c from master, ready from slave
// output: valid/result (DATASIZE+1 bits) from master, ready from slave
interface math_computer_input_itf;
  import math_computer_pkg::*;
  logic                valid;
  logic                ready;
  logic [DATASIZE-1:0] a;
  logic [DATASIZE-1:0] b;
  logic [DATASIZE-1:0] c;
  modport master(output valid, a, b, c, input ready);
  modport slave(input valid, a, b, c, output ready);
endinterface

interface math_computer_output_itf;
  import math_computer_pkg::*;
  logic              valid;
  logic              ready;
  logic [DATASIZE:0] result;
  modport master(output valid, result, input ready);
  modport slave(input valid, result, output ready);
endinterface

// File: rtl/math_computer_driver.sv
// math_computer_driver: issues a sequence of a/b/c operations and checks each a+b result
// clk, rst (async, active-high)
// i_start/i_nb_trans/i_a_init/i_b_init: launch a sequence when idle
// input_port (master): operands out; output_port (slave): results in
// o_busy, o_done (1-cycle), o_err_count (saturating), o_timeout_flag (sticky)
module math_computer_driver
  import math_computer_pkg::*;
#(
  parameter int NB_TRANS_W = 8,
  parameter int TIMEOUT    = MC_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [NB_TRANS_W-1:0]    i_nb_trans,
  input  logic [DATASIZE-1:0]      i_a_init,
  input  logic [DATASIZE-1:0]      i_b_init,
  math_computer_input_itf.master   input_port,
  math_computer_output_itf.slave   output_port,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [MC_ERR_W-1:0]      o_err_count,
  output logic                     o_timeout_flag
);
  localparam int TW = $clog2(TIMEOUT + 1);
  mc_state_e             r_state, w_nxt_state;
  logic [NB_TRANS_W-1:0] r_nb, w_nxt_nb, r_idx, w_nxt_idx, w_idx_inc;
  logic [DATASIZE-1:0]   r_a_init, w_nxt_a_init, r_b_init, w_nxt_b_init;
  logic [MC_ERR_W-1:0]   r_err, w_nxt_err;
  logic                  r_tmo_flag, w_nxt_tmo_flag;
  logic [TW-1:0]         r_tmo_cnt, w_nxt_tmo_cnt;
  logic [DATASIZE-1:0]   w_a, w_b;
  logic [DATASIZE:0]     w_exp;
  logic                  w_in_hs, w_out_hs, w_send;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_nb       <= '0;
      r_idx      <= '0;
      r_a_init   <= '0;
      r_b_init   <= '0;
      r_err      <= '0;
      r_tmo_flag <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_nb       <= w_nxt_nb;
      r_idx      <= w_nxt_idx;
      r_a_init   <= w_nxt_a_init;
      r_b_init   <= w_nxt_b_init;
      r_err      <= w_nxt_err;
      r_tmo_flag <= w_nxt_tmo_flag;
      r_tmo_cnt  <= w_nxt_tmo_cnt;
    end
  end
  // Operands are derived from the transaction index, so nothing but the index advances per transaction.
  always_comb begin
    w_send             = r_state == SEND;
    w_a                = r_a_init + DATASIZE'(r_idx);
    w_b                = r_b_init - DATASIZE'(r_idx);
    w_exp              = {1'b0, w_a} + {1'b0, w_b};
    input_port.valid   = w_send;
    input_port.a       = w_send ? w_a : '0;
    input_port.b       = w_send ? w_b : '0;
    input_port.c       = w_send ? w_a ^ w_b : '0;
    output_port.ready  = r_state == WAIT_RES;
    w_in_hs            = input_port.valid && input_port.ready;
    w_out_hs           = output_port.valid && output_port.ready;
    w_idx_inc          = r_idx + 1'b1;
    o_busy             = r_state != IDLE;
    o_done             = r_state == FINISH;
    o_err_count        = r_err;
    o_timeout_flag     = r_tmo_flag;
  end
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_nb       = r_nb;
    w_nxt_idx      = r_idx;
    w_nxt_a_init   = r_a_init;
    w_nxt_b_init   = r_b_init;
    w_nxt_err      = r_err;
    w_nxt_tmo_flag = r_tmo_flag;
    w_nxt_tmo_cnt  = r_tmo_cnt;
    case (r_state)
      IDLE: if (i_start) begin
        w_nxt_nb       = i_nb_trans;
        w_nxt_a_init   = i_a_init;
        w_nxt_b_init   = i_b_init;
        w_nxt_idx      = '0;
        w_nxt_err      = '0;
        w_nxt_tmo_flag = 1'b0;
        w_nxt_state    = i_nb_trans == '0 ? FINISH : SEND;
      end
      SEND: if (w_in_hs) begin
        w_nxt_state   = WAIT_RES;
        w_nxt_tmo_cnt = TW'(TIMEOUT);
      end
      WAIT_RES: if (w_out_hs) begin
        w_nxt_err   = (output_port.result != w_exp && r_err != '1) ? r_err + 1'b1 : r_err;
        w_nxt_idx   = w_idx_inc;
        w_nxt_state = w_idx_inc == r_nb ? FINISH : SEND;
      end else if (r_tmo_cnt <= TW'(1)) begin
        // The last waiting cycle expired: abandon the rest of the sequence.
        w_nxt_tmo_flag = 1'b1;
        w_nxt_state    = FINISH;
      end else begin
        w_nxt_tmo_cnt = r_tmo_cnt - 1'b1;
      end
      default: w_nxt_state = IDLE;
    endcase
  end
endmodule
